chunked_seq_adder: RTL and testbench

- Parametrised successor to the fixed 8-bit combinational adder. Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, with a registered carry between chunks.
- Trades latency for a small per-cycle adder, which keeps the LUT/gate count low for large WIDTH in the circuit flow.
- Valid/ready handshake on both sides; reports carry-out and signed overflow.

---
 rtl/chunked_seq_adder.sv | 167 ++++++++++++++++
 tb/tb_chunked_seq_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
// Purpose: WIDTH-bit add/subtract. It processes CHUNK bits per clock and keeps a registered carry between chunks.
// Latency: the operands are accepted at edge k, and out_valid is high after edge k+NCH (NCH = WIDTH/CHUNK).
// Backpressure: in_ready is high only in IDLE. The result is held in DONE until out_ready is high.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b/sub for the operands;
//        out_valid/out_ready/sum/cout/ovf for the result; busy is high in RUN or DONE.
// Build option: define CHUNKED_ADDER_SAT_EN to clamp sum on unsigned overflow or borrow.
module chunked_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // The operands are stored in shift registers, so the active chunk is always in the low CHUNK bits.
  // b is stored already conditioned, as b' = b ^ {WIDTH{sub}}.
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] a_nxt, b_nxt, sum_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             cout_q, ovf_q;
  logic [CHUNK:0]   add_w;
  logic             last;
  logic             ovf_w;
`ifdef CHUNKED_ADDER_SAT_EN
  logic             sub_q;
`endif

  assign add_w = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  assign last  = (idx == IW'(NCH - 1));

  // On the last cycle, the low chunk holds the most significant bits of both operands.
  assign ovf_w = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (add_w[CHUNK-1] != a_q[CHUNK-1]);

  // Each new chunk result enters sum at the top and shifts down.
  // After NCH cycles, slice i of sum holds the result for chunk i.
  generate
    if (NCH > 1) begin : g_multi
      assign a_nxt   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_nxt   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
      assign sum_nxt = {add_w[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign a_nxt   = a_q;
      assign b_nxt   = b_q;
      assign sum_nxt = add_w[CHUNK-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef CHUNKED_ADDER_SAT_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;   // The +1 that completes the two's-complement of b
            idx   <= '0;
`ifdef CHUNKED_ADDER_SAT_EN
            sub_q <= sub;
`endif
          end
        end
        RUN: begin
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          carry <= add_w[CHUNK];
          idx   <= idx + IW'(1);
          sum_q <= sum_nxt;
          if (last) begin
            cout_q <= add_w[CHUNK];
            ovf_q  <= ovf_w;
`ifdef CHUNKED_ADDER_SAT_EN
            // cout/ovf above keep the raw condition; only sum is clamped.
            if (!sub_q && add_w[CHUNK]) begin
              sum_q <= '1;
            end else if (sub_q && !add_w[CHUNK]) begin
              sum_q <= '0;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Purpose: self-checking bench for chunked_seq_adder. It uses a 32/8 instance and a 32/32 (NCH=1) instance.
// Latency: the expected latency is NCH cycles from accept to out_valid.
// Backpressure: the bench stalls out_ready in DONE and offers operands while the DUT is busy.
module tb_chunked_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [31:0] a, b, sum;
  logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
  logic [31:0] a1, b1, sum1;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  chunked_seq_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full-width reference: one 33-bit addition
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    exp_t        e;
    logic [31:0] bx;
    logic [32:0] full;
    bx     = mb ^ {32{ms}};
    full   = {1'b0, ma} + {1'b0, bx} + {32'd0, ms};
    e.cout = full[32];
    e.ovf  = (ma[31] == bx[31]) && (full[31] != ma[31]);
    e.sum  = full[31:0];
`ifdef CHUNKED_ADDER_SAT_EN
    if (!ms && e.cout) e.sum = '1;
    if (ms && !e.cout) e.sum = '0;
`endif
    return e;
  endfunction

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 100);
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, sum, e.sum);
      check({tag, "_cout"}, cout, e.cout);
      check({tag, "_ovf"}, ovf, e.ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_rise"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input int lat, input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    sb.push_back(model(ta, tb_v, ts));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_out(n);
    if (lat > 0) check({tag, "_latency"}, n, lat);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    pop_compare(tag);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op("ff_plus_1", 32'h0000_00FF, 32'h1, 1'b0, 4, 0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 4, 0);
    run_op("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 4, 1);
    run_op("borrow", 32'h5, 32'h7, 1'b1, 4, 0);
    run_op("nob", 32'h7, 32'h5, 1'b1, 4, 2);

    // Stall in DONE while new operands are offered
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
    e = model(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(posedge clk); #1;
    a = 32'hAAAA_AAAA; b = 32'h1; sub = 1'b1;
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      check("hold_sum", sum, e.sum);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_idle", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    sb.push_back(model(32'hAAAA_AAAA, 32'h1, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("new_accept_busy", busy, 1);
    wait_out(n);
    check("new_latency", n, 4);
    pop_compare("new_op");

    // Reset after two RUN cycles
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 32'h0000_00FF, 32'h1, 1'b0, 4, 0);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 4, $urandom_range(0, 3));
    end

    // NCH = 1 instance
    e = model(32'h0000_00FF, 32'h1, 1'b0);
    check("n1_in_ready", in_ready1, 1);
    a1 = 32'h0000_00FF; b1 = 32'h1; sub1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid1 && n < 20);
    check("n1_out_valid", out_valid1, 1);
    check("n1_latency", n, 1);
    check("n1_sum", sum1, e.sum);
    check("n1_cout", cout1, e.cout);
    check("n1_ovf", ovf1, e.ovf);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("n1_idle", in_ready1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
